// File: rtl/luma_gain_clipper.sv
// luma_gain_clipper: luma * gain, clipped to [CLIP_MIN, CLIP_MAX], with flags for clip events.
// Latency 2 cycles (input register + output register), throughput 1 per cycle, no handshake.
// Optional macro CLIPPER_CLIP_CNT_EN builds a saturating clip-event counter on CLIP_CNT.
module luma_gain_clipper #(
  parameter logic [11:0] CLIP_MAX = 12'd255,
  parameter logic [11:0] CLIP_MIN = 12'd0,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       LUMA,
  input  logic [3:0]       GAIN,
  output logic [11:0]      PRODUCT,
  output logic             CLIP_HI,
  output logic             CLIP_LO,
  output logic [CNT_W-1:0] CLIP_CNT
);

  logic [7:0]  LUMA_Q;
  logic [3:0]  GAIN_Q;
  logic [11:0] PROD_RAW;
  logic [11:0] prod_nxt;
  logic        hi_nxt;
  logic        lo_nxt;

  // Stage 1: capture the raw operands every cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LUMA_Q <= '0;
      GAIN_Q <= '0;
    end else begin
      LUMA_Q <= LUMA;
      GAIN_Q <= GAIN;
    end
  end

  // Both operands widened to 12 bits so the full product (max 0xEF1) survives.
  assign PROD_RAW = {4'b0000, LUMA_Q} * {8'b0000_0000, GAIN_Q};

  // Clip decision; values equal to either bound are in range and unflagged.
  always_comb begin
    prod_nxt = PROD_RAW;
    hi_nxt   = 1'b0;
    lo_nxt   = 1'b0;
    if (PROD_RAW > CLIP_MAX) begin
      prod_nxt = CLIP_MAX;
      hi_nxt   = 1'b1;
    end else if (PROD_RAW < CLIP_MIN) begin
      prod_nxt = CLIP_MIN;
      lo_nxt   = 1'b1;
    end
  end

  // Stage 2: register the clipped result and its flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PRODUCT <= '0;
      CLIP_HI <= 1'b0;
      CLIP_LO <= 1'b0;
    end else begin
      PRODUCT <= prod_nxt;
      CLIP_HI <= hi_nxt;
      CLIP_LO <= lo_nxt;
    end
  end

`ifdef CLIPPER_CLIP_CNT_EN
  // Count every edge on which stage 2 loads a clipped result; stick at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CLIP_CNT <= '0;
    end else if ((hi_nxt || lo_nxt) && (CLIP_CNT != {CNT_W{1'b1}})) begin
      CLIP_CNT <= CLIP_CNT + 1'b1;
    end
  end
`else
  assign CLIP_CNT = '0;
`endif

endmodule

// File: tb/tb_luma_gain_clipper.sv
// Directed bench for luma_gain_clipper: default bounds instance plus a CLIP_MIN=16 instance.
// Inputs driven on the falling edge, outputs sampled #1 after rising edges or on falling edges.
// Expected values are hand-computed constants in the stimulus below.
module tb_luma_gain_clipper;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  LUMA;
  logic [3:0]  GAIN;
  logic [11:0] prod_def, prod_min;
  logic        hi_def, lo_def, hi_min, lo_min;
  logic [15:0] cnt_def, cnt_min;

  int n_chk = 0;
  int n_err = 0;

  luma_gain_clipper u_def (
    .CLK(CLK), .RST_N(RST_N), .LUMA(LUMA), .GAIN(GAIN),
    .PRODUCT(prod_def), .CLIP_HI(hi_def), .CLIP_LO(lo_def), .CLIP_CNT(cnt_def)
  );

  luma_gain_clipper #(.CLIP_MAX(12'd255), .CLIP_MIN(12'd16), .CNT_W(16)) u_min (
    .CLK(CLK), .RST_N(RST_N), .LUMA(LUMA), .GAIN(GAIN),
    .PRODUCT(prod_min), .CLIP_HI(hi_min), .CLIP_LO(lo_min), .CLIP_CNT(cnt_min)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one vector and wait until its result is on the outputs.
  task automatic run1(input logic [7:0] l, input logic [3:0] g);
    @(negedge CLK);
    LUMA = l;
    GAIN = g;
    @(posedge CLK);
    @(posedge CLK);
    #1;
  endtask

  // Back-to-back stream with default bounds.
  int          st_l[10]  = '{0, 1, 30, 16, 17, 25, 26, 12, 30, 5};
  int          st_g[10]  = '{0, 1, 9, 15, 15, 10, 10, 12, 15, 3};
  int          st_p[10]  = '{0, 1, 255, 240, 255, 250, 255, 144, 255, 15};
  int          st_h[10]  = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 0};

  int exp_cnt;

  initial begin
    RST_N = 1'b0;
    LUMA  = '0;
    GAIN  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_prod_def", 32'(prod_def), 32'h0);
    chk("rst_hi_def",   32'(hi_def),   32'h0);
    chk("rst_lo_def",   32'(lo_def),   32'h0);
    chk("rst_cnt_def",  32'(cnt_def),  32'h0);
    chk("rst_prod_min", 32'(prod_min), 32'h0);
    chk("rst_lo_min",   32'(lo_min),   32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // 30*15 = 450 -> clipped high; raw net probed one edge after sampling
    @(negedge CLK);
    LUMA = 8'd30;
    GAIN = 4'd15;
    @(posedge CLK);
    #1;
    chk("t1_raw", 32'(u_def.PROD_RAW), 32'h1C2);
    @(posedge CLK);
    #1;
    chk("t1_prod", 32'(prod_def), 32'h0FF);
    chk("t1_hi",   32'(hi_def),   32'h1);
    chk("t1_lo",   32'(lo_def),   32'h0);

    // 17*15 = 255 exactly: in range, no flag
    run1(8'd17, 4'd15);
    chk("t2_raw",  32'(u_def.PROD_RAW), 32'h0FF);
    chk("t2_prod", 32'(prod_def), 32'h0FF);
    chk("t2_hi",   32'(hi_def),   32'h0);

    // 255*15 = 0xEF1: full 12-bit product
    run1(8'd255, 4'd15);
    chk("t3_raw",  32'(u_def.PROD_RAW), 32'hEF1);
    chk("t3_prod", 32'(prod_def), 32'h0FF);
    chk("t3_hi",   32'(hi_def),   32'h1);
    chk("t3_hi_min", 32'(hi_min), 32'h1);

    // 3*5 = 15: in range for default, below CLIP_MIN=16 for u_min
    run1(8'd3, 4'd5);
    chk("t5_prod_def", 32'(prod_def), 32'd15);
    chk("t5_lo_def",   32'(lo_def),   32'h0);
    chk("t5_prod_min", 32'(prod_min), 32'h010);
    chk("t5_lo_min",   32'(lo_min),   32'h1);
    chk("t5_hi_min",   32'(hi_min),   32'h0);

    // gain 0: zero product, lifted to CLIP_MIN on u_min
    run1(8'd200, 4'd0);
    chk("t5g0_prod_def", 32'(prod_def), 32'h0);
    chk("t5g0_lo_def",   32'(lo_def),   32'h0);
    chk("t5g0_prod_min", 32'(prod_min), 32'h010);
    chk("t5g0_lo_min",   32'(lo_min),   32'h1);

    // 16*15 = 240 exactly at upper region, fine for both; 16*1 = CLIP_MIN boundary
    run1(8'd16, 4'd1);
    chk("min_eq_prod", 32'(prod_min), 32'h010);
    chk("min_eq_lo",   32'(lo_min),   32'h0);

    // back-to-back stream, result of vector i visible two falling edges later
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (i >= 2) begin
        chk($sformatf("st%0d_prod", i - 2), 32'(prod_def), 32'(st_p[i - 2]));
        chk($sformatf("st%0d_hi", i - 2),   32'(hi_def),   32'(st_h[i - 2]));
      end
      if (i < 10) begin
        LUMA = 8'(st_l[i]);
        GAIN = 4'(st_g[i]);
      end
    end

    // mid-stream async reset between edges
    @(negedge CLK);
    LUMA = 8'd30;
    GAIN = 4'd15;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("mrst_prod", 32'(prod_def), 32'h0);
    chk("mrst_hi",   32'(hi_def),   32'h0);
    chk("mrst_cnt",  32'(cnt_def),  32'h0);
    chk("mrst_lo_min", 32'(lo_min), 32'h0);
    @(posedge CLK);
    #1;
    chk("mrst_hold_prod", 32'(prod_def), 32'h0);

    @(negedge CLK);
    RST_N = 1'b1;
    LUMA  = 8'd20;
    GAIN  = 4'd13;
    @(negedge CLK);
    LUMA  = 8'd10;
    GAIN  = 4'd7;
    @(negedge CLK);
    chk("post_rst_prod0", 32'(prod_def), 32'h0FF);
    chk("post_rst_hi0",   32'(hi_def),   32'h1);
    LUMA  = 8'd30;
    GAIN  = 4'd15;
    @(negedge CLK);
    chk("post_rst_prod1", 32'(prod_def), 32'd70);
    chk("post_rst_hi1",   32'(hi_def),   32'h0);
    LUMA  = 8'd255;
    GAIN  = 4'd15;
    @(negedge CLK);
    chk("post_rst_prod2", 32'(prod_def), 32'h0FF);
    LUMA  = 8'd1;
    GAIN  = 4'd1;
    @(negedge CLK);
    chk("post_rst_hi3", 32'(hi_def), 32'h1);
    @(negedge CLK);
    chk("post_rst_prod4", 32'(prod_def), 32'h1);
`ifdef CLIPPER_CLIP_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    chk("cnt_after3", 32'(cnt_def), 32'(exp_cnt));

    #2;
    RST_N = 1'b0;
    #1;
    chk("cnt_rst", 32'(cnt_def), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
